// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = A - B - Bin, one 4-bit digit per clock, LSB digit first.
// Operands are captured on an accepted start and shifted right one digit per RUN cycle.
// The inter-digit borrow is held in a register. Results appear only at completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             ovf
);

    localparam int unsigned DIGITS = WIDTH / 4;
    // Keep the counter at least one bit wide so the WIDTH=4 case still elaborates.
    localparam int unsigned KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic             borrow_q;
    logic [KW-1:0]    k_q;

    logic [4:0]       dig_res;
    logic             dig_borrow;
    logic [WIDTH-1:0] part_next;
    logic [WIDTH+3:0] part_cat;
    logic             last_digit;
    logic             ovf_next;

    // Current digit subtract plus the partial result with the new digit shifted in at the top.
    always_comb begin
        dig_res    = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, borrow_q};
        dig_borrow = dig_res[4];
        part_cat   = {dig_res[3:0], part_q};
        part_next  = part_cat[WIDTH+3:4];
        last_digit = (k_q == KW'(DIGITS - 1));
        // Sign-rule form of (borrow into MSB) XOR (borrow out of MSB), valid on the top digit.
        ovf_next   = (a_q[3] ^ b_q[3]) & (a_q[3] ^ dig_res[3]);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            Bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        k_q      <= '0;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> 4;
                    b_q      <= b_q >> 4;
                    borrow_q <= dig_borrow;
                    part_q   <= part_next;
                    k_q      <= k_q + 1'b1;
                    if (last_digit) begin
                        diff    <= part_next;
                        Bout    <= dig_borrow;
                        ovf     <= ovf_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor at WIDTH=16.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int nchecks = 0;
    int nerrors = 0;

    serial_subtractor #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (a),
        .B    (b),
        .Bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .Bout (bout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: start pulse, bounded wait for done, result and latency checks.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input logic [15:0] ed, input logic eb,
                          input logic eo);
        int cyc;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd4);
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " bout"}, 32'(bout), 32'(eb));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          ndone;
        logic [15:0] seen;
        logic [16:0] full;
        logic [15:0] low;
        logic [15:0] ra, rb;
        logic        rbi, rovf;
        logic [15:0] nexta;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst bout", 32'(bout), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("t2 wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("t3a ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("t3b ovf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("t4 ripple", 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("eq", 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Start while busy must be ignored.
        @(negedge clk);
        a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0; a = 16'h0000;
        ndone = 0; seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                seen = diff;
            end
        end
        check("t5 ndone", 32'(ndone), 32'd1);
        check("t5 diff", 32'(seen), 32'h0002);

        // Reset mid-operation abandons it.
        @(negedge clk);
        a = 16'h1111; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 diff", 32'(diff), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("t6 no_done", 32'(ndone), 32'd0);
        run_op("t6 after", 16'h0009, 16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Start held high: done every 5 cycles, operands recaptured in each done cycle.
        @(negedge clk);
        a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        nexta = 16'h0200; ndone = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (done) begin
                check("held period", 32'(i % 5), 32'd4);
                check("held diff", 32'(diff), 32'(nexta - 16'h0101));
                ndone++;
                a = nexta;
                nexta = nexta + 16'h0100;
            end
        end
        check("held ndone", 32'(ndone), 32'd3);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Random operands against an independent borrow-chain model.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
            low = {1'b0, ra[14:0]} - {1'b0, rb[14:0]} - {15'd0, rbi};
            rovf = low[15] ^ full[16];
            run_op("rand", ra, rb, rbi, full[15:0], full[16], rovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
